// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Two-master round-robin arbiter for single-beat AXI reads (AR/R)
//               onto one bridge read port, one transaction in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    // master 0
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    // master 1
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    // bridge side
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic [1:0]        r_gnt;
    logic [1:0]        w_gnt_nxt;
    logic [ADDR_W-1:0] r_araddr;
    logic [ADDR_W-1:0] w_araddr_nxt;

    logic w_req;
    logic w_pick1;
    logic w_owner_rready;

    // m1 wins when it is the only requester, or on a tie when m0 went last
    assign w_req          = m0_arvalid | m1_arvalid;
    assign w_pick1        = m1_arvalid & (~m0_arvalid | ~r_last);
    assign w_owner_rready = r_gnt[1] ? m1_rready : m0_rready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_last   <= 1'b1;
            r_gnt    <= 2'b00;
            r_araddr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_gnt    <= w_gnt_nxt;
            r_araddr <= w_araddr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_gnt_nxt    = r_gnt;
        w_araddr_nxt = r_araddr;
        m0_arready   = 1'b0;
        m1_arready   = 1'b0;
        s_arvalid    = 1'b0;
        s_rready     = 1'b0;
        m0_rvalid    = 1'b0;
        m1_rvalid    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                m1_arready = w_pick1;
                m0_arready = m0_arvalid & ~w_pick1;
                if (w_req) begin
                    w_state_nxt  = ST_ADDR;
                    w_gnt_nxt    = w_pick1 ? 2'b10 : 2'b01;
                    w_araddr_nxt = w_pick1 ? m1_araddr : m0_araddr;
                end
            end
            ST_ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                s_rready  = w_owner_rready;
                m0_rvalid = r_gnt[0] & s_rvalid;
                m1_rvalid = r_gnt[1] & s_rvalid;
                if (s_rvalid && w_owner_rready) begin
                    w_last_nxt  = r_gnt[1];
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // read data/response are broadcast; only rvalid is steered
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign s_araddr = r_araddr;
    assign gnt      = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Randomized self-checking bench for axi_rd_arbiter against a
//               transaction-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  gnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic ref_last;     // index of the master served most recently

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .gnt(gnt)
    );

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_araddr = '0; m1_araddr = '0;
        m0_rready = 1'b1; m1_rready = 1'b1;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        repeat (cycles) @(posedge clk);
        #1 resetn = 1'b1;
        ref_last = 1'b1;
    endtask

    // One full transaction; requests must already be presented on arvalid.
    task automatic serve(input logic [31:0] data, input logic [1:0] resp,
                         input int aw, input int rw);
        logic        win;
        logic [31:0] ea;
        logic [1:0]  eg;
        s_rvalid = 1'b0;
        #1;
        win = (m0_arvalid && m1_arvalid) ? ~ref_last : m1_arvalid;
        ea  = win ? m1_araddr : m0_araddr;
        eg  = win ? 2'b10 : 2'b01;
        n_tests++;
        if (m0_arready !== !win || m1_arready !== win) begin
            n_fail++;
            $display("FAIL idle_arready: got m0=%b m1=%b want m0=%b m1=%b", m0_arready, m1_arready, !win, win);
        end
        n_tests++;
        if (gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_gnt: got %b want 00", gnt);
        end
        @(posedge clk); #1;
        if (win) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        s_arready = (aw == 0);
        s_rvalid  = 1'b1;              // unsolicited beat while address phase runs
        s_rdata   = $urandom;
        #1;
        n_tests++;
        if (s_arvalid !== 1'b1 || s_araddr !== ea || gnt !== eg) begin
            n_fail++;
            $display("FAIL addr_phase: got arvalid=%b addr=%h gnt=%b want 1 %h %b", s_arvalid, s_araddr, gnt, ea, eg);
        end
        n_tests++;
        if ({m0_arready, m1_arready, s_rready, m0_rvalid, m1_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL addr_quiet: got arready=%b%b s_rready=%b rvalid=%b%b want all 0",
                     m0_arready, m1_arready, s_rready, m0_rvalid, m1_rvalid);
        end
        for (int k = 0; k < aw; k++) begin
            @(posedge clk); #1;
            if (k == aw - 1) s_arready = 1'b1;
            #1;
            n_tests++;
            if (s_arvalid !== 1'b1 || s_araddr !== ea) begin
                n_fail++;
                $display("FAIL addr_hold: got arvalid=%b addr=%h want 1 %h", s_arvalid, s_araddr, ea);
            end
        end
        @(posedge clk); #1;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = data;
        s_rresp   = resp;
        if (win) begin m1_rready = (rw == 0); m0_rready = 1'($urandom); end
        else     begin m0_rready = (rw == 0); m1_rready = 1'($urandom); end
        #1;
        n_tests++;
        if ((win ? m1_rvalid : m0_rvalid) !== 1'b1 || (win ? m0_rvalid : m1_rvalid) !== 1'b0 ||
            (win ? m1_rdata : m0_rdata) !== data || (win ? m1_rresp : m0_rresp) !== resp) begin
            n_fail++;
            $display("FAIL data_route: got rvalid=%b%b rdata=%h rresp=%b want owner m%0d rdata=%h rresp=%b",
                     m1_rvalid, m0_rvalid, win ? m1_rdata : m0_rdata, win ? m1_rresp : m0_rresp, win, data, resp);
        end
        n_tests++;
        if (s_rready !== (rw == 0) || s_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL data_ready: got s_rready=%b s_arvalid=%b want %b 0", s_rready, s_arvalid, rw == 0);
        end
        for (int k = 0; k < rw; k++) begin
            @(posedge clk); #1;
            if (k == rw - 1) begin
                if (win) m1_rready = 1'b1; else m0_rready = 1'b1;
            end
            #1;
            n_tests++;
            if ((win ? m1_rvalid : m0_rvalid) !== 1'b1 || s_rready !== (k == rw - 1) || gnt !== eg ||
                m0_arready !== 1'b0 || m1_arready !== 1'b0) begin
                n_fail++;
                $display("FAIL data_stall: got rvalid=%b s_rready=%b gnt=%b arready=%b%b want 1 %b %b 00",
                         win ? m1_rvalid : m0_rvalid, s_rready, gnt, m0_arready, m1_arready, k == rw - 1, eg);
            end
        end
        @(posedge clk); #1;
        s_rvalid = 1'b0;
        ref_last = win;
        #1;
        n_tests++;
        if (gnt !== 2'b00 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL complete: got gnt=%b rvalid=%b%b want 00 00", gnt, m0_rvalid, m1_rvalid);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_araddr = '0; m1_araddr = '0;
        m0_rready = 1'b1; m1_rready = 1'b1;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (gnt !== 2'b00 || s_arvalid !== 1'b0 || s_araddr !== 32'h0 || s_rready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bridge: got gnt=%b arvalid=%b addr=%h rready=%b want 00 0 0 0", gnt, s_arvalid, s_araddr, s_rready);
        end
        n_tests++;
        if ({m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_masters: got arready=%b%b rvalid=%b%b want 0000", m0_arready, m1_arready, m0_rvalid, m1_rvalid);
        end
        resetn   = 1'b1;
        ref_last = 1'b1;
    endtask

    task automatic test_single_m0();
        m0_araddr  = 32'h0;
        m0_arvalid = 1'b1;
        serve(32'h1122_3344, 2'b00, 0, 0);
    endtask

    task automatic test_round_robin();
        do_reset(1);
        m0_araddr = 32'h10; m1_araddr = 32'h20;
        m0_arvalid = 1'b1;  m1_arvalid = 1'b1;
        #1;
        n_tests++;
        if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_first: got arready m0=%b m1=%b want 1 0", m0_arready, m1_arready);
        end
        serve($urandom, 2'b00, 0, 0);
        serve($urandom, 2'b00, 0, 0);
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        serve($urandom, 2'b01, 0, 0);
        serve($urandom, 2'b10, 0, 0);
    endtask

    task automatic test_rready_stall();
        m1_araddr  = 32'h4;
        m1_arvalid = 1'b1;
        serve($urandom, 2'b00, 0, 5);
    endtask

    task automatic test_addr_wait();
        m0_araddr  = $urandom;
        m0_arvalid = 1'b1;
        serve($urandom, 2'b11, 4, 0);
    endtask

    task automatic test_reset_mid();
        m0_araddr = 32'h40; m0_arvalid = 1'b1; m0_rready = 1'b0;
        @(posedge clk); #1;
        m0_arvalid = 1'b0; s_arready = 1'b1;
        @(posedge clk); #1;
        s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if (m0_rvalid !== 1'b1 || gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_data: got rvalid=%b gnt=%b want 1 01", m0_rvalid, gnt);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        m0_rready = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 2'b00 || s_rready !== 1'b0 || m0_rvalid !== 1'b0 || s_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got gnt=%b s_rready=%b rvalid=%b arvalid=%b want 00 0 0 0", gnt, s_rready, m0_rvalid, s_arvalid);
        end
        s_rvalid = 1'b0;
        ref_last = 1'b1;
        m0_araddr = 32'h44; m0_arvalid = 1'b1;
        serve(32'h5566_7788, 2'b00, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            if (!m0_arvalid && $urandom_range(1, 0) == 1) begin m0_araddr = $urandom; m0_arvalid = 1'b1; end
            if (!m1_arvalid && $urandom_range(1, 0) == 1) begin m1_araddr = $urandom; m1_arvalid = 1'b1; end
            if (!m0_arvalid && !m1_arvalid) begin
                if ($urandom_range(1, 0) == 1) begin m1_araddr = $urandom; m1_arvalid = 1'b1; end
                else                           begin m0_araddr = $urandom; m0_arvalid = 1'b1; end
            end
            serve($urandom, 2'($urandom), $urandom_range(2, 0), $urandom_range(2, 0));
        end
        while (m0_arvalid || m1_arvalid) serve($urandom, 2'b00, 0, 0);
    endtask

    initial begin
        ref_last = 1'b1;
        test_reset();
        test_single_m0();
        test_round_robin();
        test_rready_stall();
        test_addr_wait();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
